// File: rtl/dm_port_arbiter.sv
// dm_port_arbiter: shares the single-ported 4 KB data memory between the CPU
// load/store path and a debug/loader port.
//   clk_i, rst_i             clock, synchronous active-high reset
//   cpu_*_i / cpu_*_o        CPU request (req/we/addr/wdata), grant, read return
//   dbg_*_i / dbg_*_o        debug request (plus lock for bursts), grant, read return
//   misalign_o               registered pulse for a granted access with addr[1:0] != 0
//   dm_we_o/addr_o/wdata_o   memory command, dm_rdata_i combinational read data
// Grants and the memory command are combinational; read data, rvalid and
// misalign are registered one cycle after the grant.
module dm_port_arbiter #(
  parameter int unsigned DM_AW  = 10,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [11:0]       cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_wdata_i,
  output logic              cpu_gnt_o,
  output logic              cpu_rvalid_o,
  output logic [DATA_W-1:0] cpu_rdata_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic              dbg_lock_i,
  input  logic [11:0]       dbg_addr_i,
  input  logic [DATA_W-1:0] dbg_wdata_i,
  output logic              dbg_gnt_o,
  output logic              dbg_rvalid_o,
  output logic [DATA_W-1:0] dbg_rdata_o,
  output logic              misalign_o,
  output logic              dm_we_o,
  output logic [DM_AW-1:0]  dm_addr_o,
  output logic [DATA_W-1:0] dm_wdata_o,
  input  logic [DATA_W-1:0] dm_rdata_i
);

  localparam int unsigned AW = 12;

  // Locked implies the debug port was the last owner, so three states suffice.
  typedef enum logic [1:0] {
    ST_CPU_LAST = 2'd0,
    ST_DBG_LAST = 2'd1,
    ST_DBG_LOCK = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic              cpu_gnt, dbg_gnt, any_gnt, aligned;
  logic              g_we;
  logic [AW-1:0]     g_addr;
  logic              cpu_rvalid_q, dbg_rvalid_q, misalign_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;

  // Ownership state register
  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_DBG_LAST;
    else       state_q <= state_d;
  end

  // Grant decision and ownership next state
  always_comb begin
    state_d = state_q;
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!rst_i) begin
      unique case (state_q)
        ST_DBG_LOCK: dbg_gnt = dbg_req_i;
        ST_CPU_LAST: begin
          dbg_gnt = dbg_req_i;
          cpu_gnt = cpu_req_i & ~dbg_req_i;
        end
        default: begin
          cpu_gnt = cpu_req_i;
          dbg_gnt = dbg_req_i & ~cpu_req_i;
        end
      endcase
      if (cpu_gnt)                    state_d = ST_CPU_LAST;
      else if (dbg_gnt)               state_d = dbg_lock_i ? ST_DBG_LOCK : ST_DBG_LAST;
      else if (state_q == ST_DBG_LOCK) state_d = ST_DBG_LAST; // debug released the bus
    end
  end

  // Memory command follows the granted requester, CPU inputs when idle
  always_comb begin
    any_gnt    = cpu_gnt | dbg_gnt;
    g_we       = dbg_gnt ? dbg_we_i   : cpu_we_i;
    g_addr     = dbg_gnt ? dbg_addr_i : cpu_addr_i;
    dm_wdata_o = dbg_gnt ? dbg_wdata_i : cpu_wdata_i;
    aligned    = (g_addr[1:0] == 2'b00);
    dm_addr_o  = DM_AW'(g_addr[AW-1:2]);
    dm_we_o    = any_gnt & g_we & aligned; // misaligned writes are dropped
  end

  // Registered read return and misalign pulse
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      cpu_rvalid_q <= cpu_gnt & ~cpu_we_i;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we_i;
      if (cpu_gnt & ~cpu_we_i) cpu_rdata_q <= dm_rdata_i;
      if (dbg_gnt & ~dbg_we_i) dbg_rdata_q <= dm_rdata_i;
      misalign_q   <= any_gnt & ~aligned;
    end
  end

  assign cpu_gnt_o    = cpu_gnt;
  assign dbg_gnt_o    = dbg_gnt;
  assign cpu_rvalid_o = cpu_rvalid_q;
  assign dbg_rvalid_o = dbg_rvalid_q;
  assign cpu_rdata_o  = cpu_rdata_q;
  assign dbg_rdata_o  = dbg_rdata_q;
  assign misalign_o   = misalign_q;

endmodule
